// File: rtl/cpu_trace_buffer.sv
// Circular trace of committed pc/inst pairs with a cycle stamp, stopped by a
// PC trigger plus a fixed post-trigger window, then replayed oldest first.
module cpu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int POST   = 4,
    parameter int CYC_W  = 32
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0]       inst,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [31:0]       trig_pc,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_pc,
    output logic [31:0]       rd_inst,
    output logic [CYC_W-1:0]  rd_cycle,
    output logic [ADDR_W:0]   count,
    output logic              wrapped,
    output logic [1:0]        state,
    output logic              done
);

    localparam int PW = (POST < 1) ? 1 : $clog2(POST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CYC_W-1:0]  cycle_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [PW-1:0]     post_cnt;
    logic              do_write;
    logic              trig_hit;
    logic              rd_fire;
    logic              full;

    logic [31:0]       mem_pc   [DEPTH];
    logic [31:0]       mem_inst [DEPTH];
    logic [CYC_W-1:0]  mem_cyc  [DEPTH];

    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign rd_valid = (state_q == S_DONE) && (count != '0);
    assign rd_fire  = rd_valid && rd_ready && !arm;
    assign done     = (state_q == S_DONE);
    assign state    = state_q;

    // arm overrides everything, including a pending read handshake in DONE
    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        trig_hit = 1'b0;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: begin
                    do_write = 1'b1;
                    if (trig_en && (pc == trig_pc)) begin
                        trig_hit = 1'b1;
                        state_d  = (POST == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    do_write = 1'b1;
                    if (post_cnt == PW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
            if (arm) begin
                wr_ptr   <= '0;
                count    <= '0;
                wrapped  <= 1'b0;
                post_cnt <= '0;
            end else begin
                if (trig_hit) begin
                    post_cnt <= PW'(POST);
                end else if (state_q == S_POST) begin
                    post_cnt <= post_cnt - PW'(1);
                end
                if (do_write) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (full) begin
                        wrapped <= 1'b1;
                    end else begin
                        count <= count + (ADDR_W+1)'(1);
                    end
                end
                // The oldest entry sits just past the final write once the buffer has lapped
                if (do_write && (state_d == S_DONE)) begin
                    rd_ptr <= (wrapped || full) ? (wr_ptr + ADDR_W'(1)) : '0;
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                    count  <= count - (ADDR_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_write) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= inst;
            mem_cyc[wr_ptr]  <= cycle_cnt;
        end
    end

    // Memory is untouched in DONE, so the combinational head stays stable while stalled
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr]   : '0;
    assign rd_inst  = rd_valid ? mem_inst[rd_ptr] : '0;
    assign rd_cycle = rd_valid ? mem_cyc[rd_ptr]  : '0;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: table-driven capture scenarios,
// hand-written corner sequences and randomized traffic against a queue model.
module tb_cpu_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int POST   = 4;
    localparam int CYC_W  = 32;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              arm;
    logic              trig_en;
    logic [31:0]       trig_pc;
    logic              rd_ready;
    logic              rd_valid;
    logic [31:0]       rd_pc;
    logic [31:0]       rd_inst;
    logic [CYC_W-1:0]  rd_cycle;
    logic [ADDR_W:0]   count;
    logic              wrapped;
    logic [1:0]        state;
    logic              done;

    always #5 clk_in = ~clk_in;

    cpu_trace_buffer #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST(POST), .CYC_W(CYC_W)
    ) dut (
        .clk_in(clk_in), .reset(reset), .pc(pc), .inst(inst), .arm(arm),
        .trig_en(trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_cycle(rd_cycle),
        .count(count), .wrapped(wrapped), .state(state), .done(done)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [CYC_W-1:0] cyc;
    } entry_t;

    typedef struct {
        bit          trig_en;
        logic [31:0] trig_pc;
        int          exp_count;
        bit          exp_wrapped;
        logic [31:0] exp_first_pc;
        logic [31:0] exp_last_pc;
    } vec_t;

    // Reference model: the trace is simply the most recent DEPTH entries
    entry_t           m_q[$];
    int               m_state;
    bit               m_wrapped;
    int               m_post_left;
    logic [CYC_W-1:0] m_cycle;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_state     = 0;
        m_wrapped   = 1'b0;
        m_post_left = 0;
        m_cycle     = '0;
    endtask

    task automatic modelEdge(input bit a, input bit te, input logic [31:0] tp, input bit rdy);
        entry_t e;
        if (a) begin
            m_q.delete();
            m_wrapped = 1'b0;
            m_state   = 1;
        end else if (m_state == 1 || m_state == 2) begin
            if (m_q.size() == DEPTH) begin
                void'(m_q.pop_front());
                m_wrapped = 1'b1;
            end
            e.pc   = pc;
            e.inst = inst;
            e.cyc  = m_cycle;
            m_q.push_back(e);
            if (m_state == 1) begin
                if (te && pc == tp) begin
                    if (POST == 0) m_state = 3;
                    else begin
                        m_state     = 2;
                        m_post_left = POST;
                    end
                end
            end else begin
                m_post_left--;
                if (m_post_left == 0) m_state = 3;
            end
        end else if (m_state == 3) begin
            if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        end
        m_cycle = m_cycle + 1;
    endtask

    task automatic checkAll(input string tag);
        bit exp_valid;
        exp_valid = (m_state == 3) && (m_q.size() != 0);
        checkOutput({tag, " state"}, 64'(state), 64'(m_state));
        checkOutput({tag, " count"}, 64'(count), 64'(m_q.size()));
        checkOutput({tag, " wrapped"}, 64'(wrapped), 64'(m_wrapped));
        checkOutput({tag, " done"}, 64'(done), 64'(m_state == 3));
        checkOutput({tag, " rd_valid"}, 64'(rd_valid), 64'(exp_valid));
        if (exp_valid) begin
            checkOutput({tag, " rd_pc"}, 64'(rd_pc), 64'(m_q[0].pc));
            checkOutput({tag, " rd_inst"}, 64'(rd_inst), 64'(m_q[0].inst));
            checkOutput({tag, " rd_cycle"}, 64'(rd_cycle), 64'(m_q[0].cyc));
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge
    task automatic applyStimulus(input bit a, input bit te, input logic [31:0] tp,
                                 input bit rdy, input string tag);
        arm      = a;
        trig_en  = te;
        trig_pc  = tp;
        rd_ready = rdy;
        @(posedge clk_in);
        modelEdge(a, te, tp, rdy);
        @(negedge clk_in);
        checkAll(tag);
        pc   = pc + 32'd4;
        inst = $urandom;
    endtask

    task automatic runUntil(input bit te, input logic [31:0] tp, input int target,
                            input int budget, input string tag);
        for (int k = 0; k < budget && m_state != target; k++) begin
            applyStimulus(1'b0, te, tp, 1'b0, tag);
        end
        checkOutput({tag, " reached"}, 64'(state), 64'(target));
    endtask

    task automatic drain(input int budget, input string tag);
        for (int k = 0; k < budget && m_q.size() != 0; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, tag);
        end
        checkOutput({tag, " drained"}, 64'(rd_valid), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        int          beats;
        logic [31:0] first_pc;
        logic [31:0] last_pc;
        bit          a;
        bit          te;
        logic [31:0] tp;

        vecs[0] = '{1'b1, 32'h00400020, 13, 1'b0, 32'h00400000, 32'h00400030};
        vecs[1] = '{1'b1, 32'h00400080, 16, 1'b1, 32'h00400054, 32'h00400090};
        vecs[2] = '{1'b1, 32'h00400000,  5, 1'b0, 32'h00400000, 32'h00400010};
        vecs[3] = '{1'b1, 32'h0040003C, 16, 1'b1, 32'h00400010, 32'h0040004C};

        reset = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
        pc = 32'h0; inst = 32'h0;
        repeat (2) @(negedge clk_in);
        checkOutput("reset state", 64'(state), 64'(0));
        checkOutput("reset count", 64'(count), 64'(0));
        checkOutput("reset wrapped", 64'(wrapped), 64'(0));
        checkOutput("reset rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset rd_pc", 64'(rd_pc), 64'(0));
        checkOutput("reset rd_cycle", 64'(rd_cycle), 64'(0));
        reset = 1'b0;
        modelReset();

        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, pc, 1'b1, "idle");

        // Table-driven capture windows
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, vecs[i].trig_en, vecs[i].trig_pc, 1'b0, "tbl arm");
            pc = 32'h00400000;
            runUntil(vecs[i].trig_en, vecs[i].trig_pc, 3, 80, "tbl cap");
            checkOutput("tbl count", 64'(count), 64'(vecs[i].exp_count));
            checkOutput("tbl wrapped", 64'(wrapped), 64'(vecs[i].exp_wrapped));
            beats = 0; first_pc = '0; last_pc = '0;
            for (int k = 0; k < 40 && rd_valid; k++) begin
                if (beats == 0) first_pc = rd_pc;
                last_pc = rd_pc;
                beats++;
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, "tbl rd");
            end
            checkOutput("tbl beats", 64'(beats), 64'(vecs[i].exp_count));
            checkOutput("tbl first pc", 64'(first_pc), 64'(vecs[i].exp_first_pc));
            checkOutput("tbl last pc", 64'(last_pc), 64'(vecs[i].exp_last_pc));
            checkOutput("tbl end valid", 64'(rd_valid), 64'(0));
        end

        // Stalled readout: ready pattern 1,0,0 repeating
        applyStimulus(1'b1, 1'b1, 32'h00400020, 1'b0, "stall arm");
        pc = 32'h00400000;
        runUntil(1'b1, 32'h00400020, 3, 40, "stall cap");
        for (int k = 0; k < 60 && m_q.size() != 0; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, (k % 3) == 0, "stall rd");
        end
        checkOutput("stall count", 64'(count), 64'(0));
        checkOutput("stall valid", 64'(rd_valid), 64'(0));

        // Free-running capture with no trigger
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, "free arm");
        pc = 32'h00400000;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h00400000, 1'b0, "free");
            if (k == 16) begin
                checkOutput("free count16", 64'(count), 64'(16));
                checkOutput("free wrapped16", 64'(wrapped), 64'(0));
            end
            if (k == 17) checkOutput("free wrapped17", 64'(wrapped), 64'(1));
        end
        checkOutput("free state", 64'(state), 64'(1));
        checkOutput("free done", 64'(done), 64'(0));

        // Reset pulse in the middle of the post-trigger window
        applyStimulus(1'b1, 1'b1, 32'h00400008, 1'b0, "rst arm");
        pc = 32'h00400000;
        runUntil(1'b1, 32'h00400008, 2, 20, "rst cap");
        applyStimulus(1'b0, 1'b1, 32'h00400008, 1'b0, "rst post");
        #1 reset = 1'b1;
        #1;
        checkOutput("rst state", 64'(state), 64'(0));
        checkOutput("rst count", 64'(count), 64'(0));
        checkOutput("rst rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("rst done", 64'(done), 64'(0));
        #1 reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 1'b1, 32'h00400004, 1'b0, "rst rearm");
        pc = 32'h00400000;
        runUntil(1'b1, 32'h00400004, 3, 20, "rst recap");
        checkOutput("rst recap count", 64'(count), 64'(6));
        drain(20, "rst rd");

        // arm together with a read handshake in DONE
        applyStimulus(1'b1, 1'b1, 32'h00400020, 1'b0, "rearm arm");
        pc = 32'h00400000;
        runUntil(1'b1, 32'h00400020, 3, 40, "rearm cap");
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, "rearm rd");
        checkOutput("rearm count5", 64'(count), 64'(5));
        applyStimulus(1'b1, 1'b1, 32'h00400020, 1'b1, "rearm hit");
        checkOutput("rearm state", 64'(state), 64'(1));
        checkOutput("rearm count0", 64'(count), 64'(0));
        checkOutput("rearm wrapped", 64'(wrapped), 64'(0));
        checkOutput("rearm valid", 64'(rd_valid), 64'(0));
        pc = 32'h00400000;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, "rearm first");
        checkOutput("rearm count1", 64'(count), 64'(1));

        // Randomized traffic
        te = 1'b1; tp = 32'h0;
        for (int k = 0; k < 1000; k++) begin
            a = (k == 0) || ($urandom_range(0, 39) == 0);
            if (a) begin
                te = ($urandom_range(0, 3) != 0);
                tp = pc + 32'd4 * 32'($urandom_range(1, 45));
            end
            if ($urandom_range(0, 63) == 0) pc = $urandom & 32'hFFFF_FFFC;
            applyStimulus(a, te, tp, 1'($urandom_range(0, 1)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Downstream observer of the single-cycle CPU top: samples the committed `pc`/`inst` pair on every clock into a circular trace memory, alongside a free-running cycle stamp.
- Stops on a programmable PC trigger after a fixed number of post-trigger entries.
- Replays the captured window, oldest first, over a valid/ready read port.
- Used in the CPU bench and on board to debug instruction flow without file dumps.

Parameters:
- DEPTH, 16, number of trace entries; power of two, >= 2
- ADDR_W, 4, log2(DEPTH)
- POST, 4, entries written after the trigger entry (0 allowed)
- CYC_W, 32, cycle-stamp width

Ports:
- clk_in  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- pc  input  32  CPU current PC
- inst  input  32  CPU current instruction
- arm  input  1  start or restart capture
- trig_en  input  1  enables PC-match trigger
- trig_pc  input  32  trigger PC value
- rd_ready  input  1  consumer accepts head entry
- rd_valid  output  1  head entry valid
- rd_pc  output  32  head entry PC
- rd_inst  output  32  head entry instruction
- rd_cycle  output  CYC_W  head entry cycle stamp
- count  output  ADDR_W+1  valid entries held
- wrapped  output  1  older entries were overwritten
- state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3
- done  output  1  state==DONE

Behaviour:
- **Reset (async, immediate):**
  - state=IDLE, count=0, wrapped=0, rd_valid=0, done=0, rd_* = 0, cycle counter=0.
  - Write pointer, read pointer and post counter = 0.
  - Memory contents are don't-care.
  - Reset asserted mid-capture or mid-readout aborts with no residue.
- **Cycle counter:** increments every clock, wraps modulo 2^CYC_W.
- **arm (priority over all else):**
  - Sampled at an edge in any state: next state=ARMED; wr_ptr, count, wrapped and post counter cleared.
  - No entry is written on the arm edge.
  - In DONE, a simultaneous rd handshake is discarded.
- **IDLE:** no writes; waits for arm.
- **ARMED:**
  - At every edge, writes {cycle counter, pc, inst} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
  - wrapped is set when a write occurs with count==DEPTH.
  - If trig_en && pc==trig_pc at that edge: the entry is still written, and the next state is POST with post counter=POST, or DONE directly if POST==0.
- **POST:**
  - Writes exactly as in ARMED; trigger comparison is ignored.
  - Transitions to DONE on the edge performing the POST-th post-trigger write.
- **DONE:**
  - No writes.
  - Read pointer starts at the oldest entry: wr_ptr if wrapped, else 0.
  - rd_valid=(count!=0). rd_pc/rd_inst/rd_cycle show the head entry whenever rd_valid=1 and are held stable while rd_ready=0.
  - On an edge with rd_valid&&rd_ready: read pointer advances modulo DEPTH, count decrements, and new head data is visible after that edge.
  - At count==0: rd_valid=0, remain in DONE until arm.
- Outside DONE, rd_valid=0.
- **Register file:** memory may be a register array or inferred RAM. Read latency must still satisfy the head-stable rule; implement a registered head entry with a prefetch if RAM is used.

Test Plan (DEPTH=16, POST=4; pc starts 0x00400000, +4 per cycle from the first ARMED edge):
1. Arm, trig_en=1, trig_pc=0x00400020 -> 13 writes, DONE, count=13, wrapped=0. Readout with rd_ready=1 gives pc 0x00400000..0x00400030 over 13 beats, rd_cycle consecutive +1 each, then rd_valid=0.
2. Arm, trig_pc=0x00400080 -> 37 writes, count=16, wrapped=1. Readout gives pc 0x00400054..0x00400090 in order.
3. DONE with rd_ready pattern 1,0,0,1,... -> rd_pc/rd_inst/rd_cycle unchanged during the 0 cycles; no entry lost or duplicated; count decrements only on handshake edges.
4. trig_en=0 for 40 cycles -> state stays ARMED. count reaches 16 after the 16th write; wrapped=1 after the 17th write; done=0.
5. Assert reset for half a cycle during POST -> state=0, count=0, rd_valid=0, done=0 immediately, before the next edge. The next arm restarts cleanly.
6. In DONE with count=5, assert arm and rd_ready together -> next state ARMED, count=0, wrapped=0, rd_valid=0. The first new entry appears at the following edge.
